div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider; the responder that the EX stage starts for DIV/DIVU.

---
 rtl/div_unit.sv | 92 +++++++++
 tb/tb_div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, DIVBYZERO, ON, END} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] dvd, dvs, rem;
   logic neg_q, neg_r;
   logic a_neg, b_neg, q_bit, last, early, ready_nxt;
   logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, dvd_nxt, quo_fix, rem_fix;
   logic [WIDTH:0] part;
   logic [2*WIDTH-1:0] result_nxt;
   assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
   assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
   assign a_mag = a_neg ? -opdata1_i : opdata1_i;
   assign b_mag = b_neg ? -opdata2_i : opdata2_i;
   assign last  = cnt == CW'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
   assign early = a_mag < b_mag;
`else
   assign early = 1'b0;
`endif
   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   // next-state logic; annul always wins over start
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_i && !annul_i)
                       state_nxt = (opdata2_i == '0) ? DIVBYZERO : early ? END : ON;
         DIVBYZERO: state_nxt = annul_i ? IDLE : END;
         ON:        state_nxt = annul_i ? IDLE : last ? END : ON;
         END:       state_nxt = (annul_i || !start_i) ? IDLE : END;
      endcase
   end
   // one restoring step, sign fix-up and next values of the registered outputs
   always_comb begin
      part       = {rem, dvd[WIDTH-1]};
      q_bit      = part >= {1'b0, dvs};
      rem_nxt    = q_bit ? part[WIDTH-1:0] - dvs : part[WIDTH-1:0];
      dvd_nxt    = {dvd[WIDTH-2:0], q_bit};
      quo_fix    = neg_q ? -dvd_nxt : dvd_nxt;
      rem_fix    = neg_r ? -rem_nxt : rem_nxt;
      ready_nxt  = (state == END) && start_i && !annul_i;
      result_nxt = (state_nxt != END) ? '0 :
                   (state == IDLE)    ? {opdata1_i, {WIDTH{1'b0}}} :
                   (state == ON)      ? {rem_fix, quo_fix} :
                   (state == END)     ? result_o : '0;
   end
   // operand latch, step datapath and registered outputs
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ready_o  <= 1'b0;
         result_o <= '0;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else begin
         ready_o  <= ready_nxt;
         result_o <= result_nxt;
         if (state == IDLE && start_i && !annul_i) begin
            dvd   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
         end else if (state == ON) begin
            dvd <= dvd_nxt;
            rem <= rem_nxt;
            cnt <= cnt + CW'(1);
         end
      end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results, latency, hold, annul and reset
module tb_div_unit;
   logic clk = 0, rst = 0, signed_div_i = 0, start_i = 0, annul_i = 0;
   logic [31:0] opdata1_i = 0, opdata2_i = 0;
   logic [63:0] result_o;
   logic ready_o;
   logic seen;
   int passed = 0, total = 0;
`ifdef DIV_EARLY_OUT_EN
   localparam int EL = 1;
`else
   localparam int EL = 33;
`endif

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .start_i(start_i), .annul_i(annul_i),
      .result_o(result_o), .ready_o(ready_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_div_i = s;
      opdata1_i = a;
      opdata2_i = b;
      start_i = 1;
   endtask

   // the next posedge is the start edge; operands are scrambled right after it
   task automatic wait_ready(input string tag, input int lat, input logic [63:0] res);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            opdata1_i = ~opdata1_i;
            opdata2_i = 32'h0;
         end
      end while (!ready_o && n < 100);
      check({tag, " latency"}, 64'(n - 1), 64'(lat));
      check({tag, " result"}, result_o, res);
   endtask

   task automatic release_op(input string tag);
      @(negedge clk);
      start_i = 0;
      @(posedge clk);
      #1;
      check({tag, " ready clr"}, 64'(ready_o), 64'd0);
      check({tag, " result clr"}, result_o, 64'd0);
   endtask

   initial begin
      #12;
      check("reset ready", 64'(ready_o), 64'd0);
      check("reset result", result_o, 64'd0);
      @(negedge clk) rst = 1;

      start_op(0, 32'd100, 32'd7);
      wait_ready("divu 100/7", 33, {32'd2, 32'd14});
      repeat (3) begin
         @(posedge clk);
         #1;
         check("hold ready", 64'(ready_o), 64'd1);
         check("hold result", result_o, {32'd2, 32'd14});
      end
      release_op("divu 100/7");

      start_op(1, 32'hFFFFFFF9, 32'd2);
      wait_ready("div -7/2", 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
      release_op("div -7/2");

      start_op(1, 32'd7, 32'hFFFFFFFE);
      wait_ready("div 7/-2", 33, {32'd1, 32'hFFFFFFFD});
      release_op("div 7/-2");

      start_op(1, 32'hFFFFFF9C, 32'hFFFFFFF9);
      wait_ready("div -100/-7", 33, {32'hFFFFFFFE, 32'd14});
      release_op("div -100/-7");

      start_op(1, 32'h80000000, 32'hFFFFFFFF);
      wait_ready("div intmin/-1", 33, {32'd0, 32'h80000000});
      release_op("div intmin/-1");

      start_op(0, 32'd5, 32'd0);
      wait_ready("divu 5/0", 2, 64'd0);
      release_op("divu 5/0");

      start_op(1, 32'h12345678, 32'd0);
      wait_ready("div x/0", 2, 64'd0);
      release_op("div x/0");

      start_op(0, 32'd3, 32'd10);
      wait_ready("divu 3/10", EL, {32'd3, 32'd0});
      release_op("divu 3/10");

      start_op(1, 32'hFFFFFFFD, 32'd10);
      wait_ready("div -3/10", EL, {32'hFFFFFFFD, 32'd0});
      release_op("div -3/10");

      start_op(0, 32'hFFFFFFFF, 32'd1);
      wait_ready("divu max/1", 33, {32'd0, 32'hFFFFFFFF});
      release_op("divu max/1");

      start_op(0, 32'd1000000007, 32'd97);
      wait_ready("divu big/97", 33, {32'd41, 32'd10309278});
      release_op("divu big/97");

      seen = 0;
      start_op(0, 32'd100, 32'd7);
      repeat (10) begin
         @(posedge clk);
         #1;
         seen |= ready_o;
      end
      @(negedge clk);
      annul_i = 1;
      opdata1_i = 32'd9;
      opdata2_i = 32'd3;
      @(posedge clk);
      #1;
      seen |= ready_o;
      check("annul ready", 64'(ready_o), 64'd0);
      check("annul result", result_o, 64'd0);
      @(negedge clk) annul_i = 0;
      wait_ready("divu 9/3 after annul", 33, {32'd0, 32'd3});
      check("annulled op never ready", 64'(seen), 64'd0);
      release_op("divu 9/3 after annul");

      start_op(0, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #2;
      rst = 0;
      start_i = 0;
      #1;
      check("reset mid-on ready", 64'(ready_o), 64'd0);
      check("reset mid-on result", result_o, 64'd0);
      @(negedge clk) rst = 1;
      start_op(0, 32'd9, 32'd3);
      wait_ready("divu 9/3 after reset", 33, {32'd0, 32'd3});

      #2;
      rst = 0;
      start_i = 0;
      #1;
      check("reset in end ready", 64'(ready_o), 64'd0);
      check("reset in end result", result_o, 64'd0);
      @(negedge clk) rst = 1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
